// File: rtl/equality_sweep_checker.sv
// equality_sweep_checker
// Exhaustive sweep engine for a WIDTH-bit equality comparator.
// The engine steps {A, B} through every value in ascending order.
// For each vector it waits SETTLE cycles and then samples eq_in.
// It counts mismatches against A==B and records the first failing vector.
module equality_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               eq_in,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // With SETTLE=0 the drive phase is skipped entirely and every vector
    // goes straight to its sample cycle.
    localparam state_t     FIRST_ST = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;
    localparam logic [3:0] CNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [IW-1:0] IDX_LAST = '1;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [WIDTH-1:0] ffa_q, ffa_d;
    logic [WIDTH-1:0] ffb_q, ffb_d;

    logic            mismatch;

    assign a_out        = idx_q[IW-1:WIDTH];
    assign b_out        = idx_q[WIDTH-1:0];
    assign busy         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done         = (state_q == S_DONE);
    assign pass         = done && (err_q == '0);
    assign err_cnt      = err_q;
    assign fail_valid   = fv_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;

    // Observed comparator result disagrees with the reference for the driven vector.
    always_comb begin
        mismatch = (eq_in != (a_out == b_out));
    end

    // Next-state and datapath updates for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = FIRST_ST;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffa_d   = '0;
                    ffb_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffa_d = a_out;
                        ffb_d = b_out;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    // a_out/b_out keep the final all-ones vector while done.
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = FIRST_ST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffa_q   <= '0;
            ffb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
        end
    end

endmodule

// File: doc/equality_sweep_checker.md
# equality_sweep_checker

Self-checking sweep engine that drives the operand inputs of a WIDTH-bit equality comparator and checks the comparator's `eq` response. It visits every (A, B) pair in ascending order, with A in the outer loop and B in the inner loop. For each pair it waits a programmable settle time, samples `eq`, and compares it with A==B. It sits beside the combinational comparator in lab/bring-up builds and reports pass/fail, an error count and the first failing vector.

## Interface
Parameters:
- `WIDTH`, default 2: operand width in bits.
- `SETTLE`, default 1: wait cycles after driving a vector before `eq_in` is sampled. Legal range 0..15.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level-sampled request to begin a sweep.
- `eq_in`  in  1: comparator equality result under test.
- `a_out`  out  WIDTH: operand A to the comparator.
- `b_out`  out  WIDTH: operand B to the comparator.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete; held until the next start or reset.
- `pass`  out  1: `done` and `err_cnt`==0.
- `err_cnt`  out  2*WIDTH+1: number of mismatching vectors.
- `fail_valid`  out  1: at least one mismatch recorded.
- `first_fail_a`  out  WIDTH: A of the first mismatching vector.
- `first_fail_b`  out  WIDTH: B of the first mismatching vector.

## Operation
- Vector index `idx` is 2*WIDTH bits, with {A, B} = idx, so `a_out`=idx[2W-1:W] and `b_out`=idx[W-1:0]. N = 2^(2*WIDTH), which is 16 for WIDTH=2.
- FSM states:
  - IDLE: start=1 → DRIVE. Clears idx, settle counter, `err_cnt`, `fail_valid`, `first_fail_*`, `done`, `pass`.
  - DRIVE: counts SETTLE cycles; when the count reaches SETTLE → SAMPLE. With SETTLE=0, DRIVE lasts zero cycles.
  - SAMPLE: one cycle. Registers the compare of `eq_in` against (a_out==b_out) at the end of the cycle.
    - On mismatch: `err_cnt`+1. If `fail_valid`=0, captures `first_fail_a/b` and sets `fail_valid`.
    - If idx==N-1 → DONE; otherwise idx+1 → DRIVE.
  - DONE: `done`=1, `busy`=0; `a_out/b_out` hold the last vector (all ones). start=1 → restart exactly as from IDLE.
- `busy`=1 in DRIVE and SAMPLE only.
- `start` asserted while `busy`=1 is ignored; there is no restart mid-sweep.
- `err_cnt` needs no saturation, because its maximum value N fits in 2W+1 bits.
- `eq_in` is treated as combinational from `a_out/b_out`. There is no input synchronizer.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_valid`=0, `first_fail_a`=0, `first_fail_b`=0. FSM in IDLE.
- Start sampled at edge E:
  - From E: `busy`=1 and vector 0 is driven.
  - Vector k is driven from edge E+k*(SETTLE+1).
  - Vector k's `eq_in` is sampled at edge E+(k+1)*(SETTLE+1).
- Completion:
  - `done`/`pass` rise and `busy` falls after edge E+N*(SETTLE+1). For the defaults this is E+32.
  - `err_cnt` and `first_fail_*` are final in the same cycle that `done` rises.
- `rst_n` low at any time, mid-sweep included: every output returns to its reset value immediately and asynchronously, and the FSM goes to IDLE. A new start is needed after release.
- `start` held high continuously: a new sweep begins on the first edge in DONE. `done` is therefore high for exactly one cycle per sweep.

## Test plan
- Correct comparator model on `eq_in`, defaults, start pulsed at edge E:
  - The bench checks that the a/b sequence is 00/00, 00/01 … 11/11 with each vector held 2 cycles.
  - At E+32: `done`=1, `pass`=1, `err_cnt`=0, `fail_valid`=0.
- `eq_in` stuck at 0 → `err_cnt`=4, `fail_valid`=1, `first_fail_a`=0, `first_fail_b`=0, `pass`=0.
- `eq_in` stuck at 1 → `err_cnt`=12, first fail A=0, B=1.
- Inverted comparator → `err_cnt`=16. Repeat with SETTLE=0 → `done` at E+16 with the same counts.
- Start re-pulsed at cycle E+5 (ignored). Then `rst_n` pulsed low at E+10 → all outputs go to 0 immediately and `busy` goes to 0. A start after release sweeps fully, with `done` at start+32.
- After a failing sweep, start again from DONE with the correct model → `err_cnt` and `fail_valid` clear, and the sweep ends with `pass`=1.
